// File: rtl/song_sequencer.sv
// song_sequencer: playback controller for the song_reader / notes_player /
// beat_generator chain. Turns one-cycle button pulses and the song_done status
// into a play enable, a song select and a flush reset for the player. It also
// counts the beats elapsed in the current song.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-low reset
//   play_button   1-cycle pulse: toggle play/pause
//   next_button   1-cycle pulse: skip to next song
//   prev_button   1-cycle pulse: go to previous song
//   repeat_mode   1 = wrap from the last song to song 0 and keep playing
//   song_done     current song finished (from song_reader)
//   beat          1-cycle beat tick (from beat_generator)
//   play          play enable to song_reader/notes_player
//   song          current song index
//   player_reset  active-high flush to song_reader/notes_player
//   song_changed  1-cycle pulse when the song index updates
//   all_done      1-cycle pulse: last song finished with repeat off
//   beat_count    beats elapsed in the current song, saturating
//
// All outputs are registered.
module song_sequencer #(
    parameter int NUM_SONGS    = 4,
    parameter int SONG_W       = 2,
    parameter int FLUSH_CYCLES = 4,
    parameter int BEAT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              repeat_mode,
    input  logic              song_done,
    input  logic              beat,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              player_reset,
    output logic              song_changed,
    output logic              all_done,
    output logic [BEAT_W-1:0] beat_count
);

    // The counter width always has at least one bit, even for FLUSH_CYCLES=1.
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [SONG_W-1:0] SONG_LAST  = SONG_W'(NUM_SONGS - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX   = {BEAT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               play_q, play_d;
    logic [SONG_W-1:0]  song_q, song_d;
    logic               player_reset_q, player_reset_d;
    logic               song_changed_q, song_changed_d;
    logic               all_done_q, all_done_d;
    logic [BEAT_W-1:0]  beat_count_q, beat_count_d;

    // Event qualification. song_done only matters while playing. next and prev
    // pressed together cancel each other, which lets play_button through.
    logic   ev_done, ev_next, ev_prev;
    logic   enter_flush;
    state_t new_ret;

    // Index wrap uses explicit compares so a non-power-of-2 NUM_SONGS works.
    logic [SONG_W-1:0] song_inc, song_dec;

    assign song_inc = (song_q == SONG_LAST) ? '0 : song_q + 1'b1;
    assign song_dec = (song_q == '0) ? SONG_LAST : song_q - 1'b1;

    assign ev_done = (state_q == ST_PLAYING) && song_done;
    assign ev_next = next_button && !prev_button;
    assign ev_prev = prev_button && !next_button;

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        flush_cnt_d    = flush_cnt_q;
        play_d         = play_q;
        song_d         = song_q;
        player_reset_d = player_reset_q;
        song_changed_d = 1'b0;
        all_done_d     = 1'b0;
        beat_count_d   = beat_count_q;
        enter_flush    = 1'b0;
        new_ret        = state_q;

        case (state_q)
            ST_PAUSED, ST_PLAYING: begin
                if (ev_done) begin
                    enter_flush = 1'b1;
                    if (song_q == SONG_LAST) begin
                        song_d     = '0;
                        new_ret    = repeat_mode ? ST_PLAYING : ST_PAUSED;
                        all_done_d = !repeat_mode;
                    end else begin
                        song_d  = song_q + 1'b1;
                        new_ret = ST_PLAYING;
                    end
                end else if (ev_next) begin
                    enter_flush = 1'b1;
                    song_d      = song_inc;
                end else if (ev_prev) begin
                    enter_flush = 1'b1;
                    song_d      = song_dec;
                end else begin
                    // A beat in the same cycle as a pause still counts: it
                    // arrived while the song was playing.
                    if (beat && (state_q == ST_PLAYING) && (beat_count_q != BEAT_MAX)) begin
                        beat_count_d = beat_count_q + 1'b1;
                    end
                    if (play_button) begin
                        state_d = (state_q == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
                        play_d  = (state_q == ST_PAUSED);
                    end
                end

                if (enter_flush) begin
                    state_d        = ST_FLUSH;
                    ret_d          = new_ret;
                    flush_cnt_d    = FLUSH_LOAD;
                    song_changed_d = 1'b1;
                    play_d         = 1'b0;
                    player_reset_d = 1'b1;
                    beat_count_d   = '0;
                end
            end

            ST_FLUSH: begin
                // The entry cycle is the first flush cycle. Leave once the
                // counter has run down to zero.
                if (flush_cnt_q == '0) begin
                    state_d        = ret_q;
                    player_reset_d = 1'b0;
                    play_d         = (ret_q == ST_PLAYING);
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d        = ST_PAUSED;
                play_d         = 1'b0;
                player_reset_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_PAUSED;
            ret_q          <= ST_PAUSED;
            flush_cnt_q    <= '0;
            play_q         <= 1'b0;
            song_q         <= '0;
            player_reset_q <= 1'b0;
            song_changed_q <= 1'b0;
            all_done_q     <= 1'b0;
            beat_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            flush_cnt_q    <= flush_cnt_d;
            play_q         <= play_d;
            song_q         <= song_d;
            player_reset_q <= player_reset_d;
            song_changed_q <= song_changed_d;
            all_done_q     <= all_done_d;
            beat_count_q   <= beat_count_d;
        end
    end

    assign play         = play_q;
    assign song         = song_q;
    assign player_reset = player_reset_q;
    assign song_changed = song_changed_q;
    assign all_done     = all_done_q;
    assign beat_count   = beat_count_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer. Each stimulus cycle runs a behavioural
// model of the player and pushes the expected output vector into a queue. A
// separate monitor pops one entry after every rising edge and compares it with
// the outputs of the DUT.
module tb_song_sequencer;

    localparam int NS   = 4;
    localparam int FC   = 4;
    localparam int BW   = 3;
    localparam int BMAX = (1 << BW) - 1;

    logic          clk;
    logic          reset;
    logic          play_button, next_button, prev_button;
    logic          repeat_mode, song_done, beat;
    logic          play;
    logic [1:0]    song;
    logic          player_reset, song_changed, all_done;
    logic [BW-1:0] beat_count;

    song_sequencer #(
        .NUM_SONGS   (NS),
        .SONG_W      (2),
        .FLUSH_CYCLES(FC),
        .BEAT_W      (BW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .play_button (play_button),
        .next_button (next_button),
        .prev_button (prev_button),
        .repeat_mode (repeat_mode),
        .song_done   (song_done),
        .beat        (beat),
        .play        (play),
        .song        (song),
        .player_reset(player_reset),
        .song_changed(song_changed),
        .all_done    (all_done),
        .beat_count  (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {play, song[1:0], player_reset, song_changed, all_done, beat_count[2:0]}
    logic [8:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    // The model describes the player as a set of properties: whether it is
    // playing, which song is selected, how many flush cycles remain, and how
    // many beats have been counted.
    bit m_playing, m_ret, m_flush;
    int m_song, m_left, m_beats;

    task automatic step(input bit rn, input bit pb, input bit nb, input bit vb,
                        input bit rm, input bit sd, input bit bt);
        bit chg, ad, go;
        @(negedge clk);
        reset = rn; play_button = pb; next_button = nb; prev_button = vb;
        repeat_mode = rm; song_done = sd; beat = bt;
        chg = 0; ad = 0; go = 0;
        if (!rn) begin
            m_playing = 0; m_ret = 0; m_flush = 0; m_left = 0; m_song = 0; m_beats = 0;
        end else if (m_flush) begin
            m_left--;
            if (m_left == 0) begin
                m_flush   = 0;
                m_playing = m_ret;
            end
        end else begin
            if (sd && m_playing) begin
                go = 1;
                if (m_song == NS - 1) begin
                    m_song = 0; m_ret = rm; ad = !rm;
                end else begin
                    m_song++; m_ret = 1;
                end
            end else if (nb && !vb) begin
                go = 1; m_song = (m_song + 1) % NS; m_ret = m_playing;
            end else if (vb && !nb) begin
                go = 1; m_song = (m_song + NS - 1) % NS; m_ret = m_playing;
            end else begin
                if (bt && m_playing && m_beats < BMAX) m_beats++;
                if (pb) m_playing = !m_playing;
            end
            if (go) begin
                m_flush = 1; m_left = FC; chg = 1; m_beats = 0; m_playing = 0;
            end
        end
        exp_q.push_back({m_playing, 2'(m_song), m_flush, chg, ad, 3'(m_beats)});
        if (!rn || pb || nb || vb || sd)
            $display("[TB] t=%0t rst_n=%0b play_b=%0b next=%0b prev=%0b rep=%0b done=%0b -> exp song=%0d play=%0b flush=%0b chg=%0b all_done=%0b",
                     $time, rn, pb, nb, vb, rm, sd, m_song, m_playing, m_flush, chg, ad);
    endtask

    task automatic idle(input int n, input bit bt);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, repeat_mode, 0, bt);
    endtask

    // Monitor: one comparison per registered output cycle.
    initial begin
        logic [8:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {play, song, player_reset, song_changed, all_done, beat_count};
                tests++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("[TB] FAIL outputs t=%0t {play,song,prst,chg,all_done,beats} got=%b expected=%b",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rm;
        reset = 0; play_button = 0; next_button = 0; prev_button = 0;
        repeat_mode = 0; song_done = 0; beat = 0;

        // Directed scenarios.
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);            // play
        idle(3, 1);                            // count beats
        step(1, 0, 1, 0, 0, 0, 0);            // next while playing
        idle(6, 1);
        step(1, 1, 0, 0, 0, 0, 0);            // pause
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);            // next -> song 2 paused
        idle(6, 0);
        step(1, 0, 0, 1, 0, 0, 0);            // prev -> song 1 paused
        idle(6, 0);
        step(1, 0, 0, 1, 0, 0, 0);            // prev -> song 0 paused
        idle(6, 0);
        step(1, 0, 0, 1, 0, 0, 0);            // prev at 0 -> song 3 paused
        idle(6, 0);
        step(1, 0, 0, 0, 0, 1, 0);            // song_done while paused: ignored
        step(1, 1, 0, 0, 0, 0, 0);            // play song 3
        step(1, 0, 0, 0, 0, 1, 0);            // last song done, repeat off
        idle(6, 0);
        step(1, 0, 0, 1, 0, 0, 0);            // back to song 3 paused
        idle(6, 0);
        step(1, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);            // last song done, repeat on
        idle(6, 0);
        step(1, 0, 1, 0, 0, 0, 0);            // song 1 playing
        idle(6, 0);
        step(1, 0, 1, 0, 0, 1, 0);            // done + next at song 1 -> 2
        step(1, 1, 1, 1, 0, 1, 1);            // everything during flush: dropped
        step(1, 0, 1, 0, 0, 0, 1);
        idle(4, 0);
        step(1, 1, 0, 0, 0, 0, 0);            // pause
        step(1, 0, 1, 1, 0, 0, 0);            // next+prev while paused: no change
        step(1, 1, 1, 1, 0, 0, 0);            // next+prev+play: play honoured
        idle(10, 1);                           // saturate beat count
        step(1, 0, 1, 0, 0, 0, 1);            // beat in flush-entry cycle dropped
        idle(2, 0);
        step(0, 0, 0, 0, 0, 0, 0);            // reset mid-flush
        idle(3, 0);

        // Randomized phase: a quiet stretch (long runs, saturation) then a busy one.
        rm = 0;
        for (int i = 0; i < 1500; i++) begin
            int p;
            bit rn, pb, nb, vb, sd, bt;
            p  = (i < 600) ? 40 : 8;
            rn = ($urandom_range(0, 149) != 0);
            pb = ($urandom_range(0, p - 1) == 0);
            nb = ($urandom_range(0, p - 1) == 0);
            vb = ($urandom_range(0, p - 1) == 0);
            sd = ($urandom_range(0, p - 1) == 0);
            bt = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) rm = !rm;
            step(rn, pb, nb, vb, rm, sd, bt);
        end

        idle(2, 0);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
